// File: rtl/link_buffer_fifo_pkg.sv
// Shared NoC definitions for the link buffer: flit geometry, default depth, flit field offsets.
package link_buffer_fifo_pkg;

  localparam int FLIT_W          = 18;
  localparam int MESH_SIZE       = 4;
  localparam int LINK_FIFO_DEPTH = 4;

  // Flit layout: [17:16] type, [15:14] dst_y, [13:12] dst_x, [11:0] payload
  localparam int COORD_W         = $clog2(MESH_SIZE);
  localparam int FLIT_PAYLOAD_LSB = 0;
  localparam int FLIT_PAYLOAD_W   = 12;
  localparam int FLIT_DST_X_LSB   = 12;
  localparam int FLIT_DST_Y_LSB   = FLIT_DST_X_LSB + COORD_W;
  localparam int FLIT_TYPE_LSB    = FLIT_DST_Y_LSB + COORD_W;
  localparam int FLIT_TYPE_W      = 2;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_e;

endpackage

// File: rtl/link_buffer_fifo_if.sv
// One req/ack flit link; master drives data/req, slave answers with ack.
interface link_buffer_fifo_if
  import link_buffer_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FLIT_W
);
  logic [DATA_WIDTH-1:0] data;
  logic                  req;
  logic                  ack;

  modport master (output data, output req, input ack);
  modport slave  (input data, input req, output ack);
endinterface

// File: rtl/link_buffer_fifo_regfile.sv
// DEPTH x DATA_WIDTH flit storage: one write port, one async read port, only entry 0 resettable.
module link_buffer_fifo_regfile
  import link_buffer_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FLIT_W,
  parameter int DEPTH      = LINK_FIFO_DEPTH,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem0_q, mem0_d;
  logic [DATA_WIDTH-1:0] memr_q [1:DEPTH-1];
  logic [DATA_WIDTH-1:0] rd_arr [DEPTH];

  always_comb begin
    mem0_d = mem0_q;
    if (we && (waddr == '0)) mem0_d = wdata;
  end

  // Entry 0 resets so data_out reads 0 straight out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mem0_q <= '0;
    else      mem0_q <= mem0_d;
  end

  always_ff @(posedge clk) begin
    if (we && (waddr != '0)) memr_q[waddr] <= wdata;
  end

  always_comb begin
    rd_arr[0] = mem0_q;
    for (int i = 1; i < DEPTH; i++) rd_arr[i] = memr_q[i];
  end

  assign rdata = rd_arr[raddr];

endmodule

// File: rtl/link_buffer_fifo.sv
// Elastic flit buffer for one mesh link: decouples upstream and downstream req/ack, order-preserving.
module link_buffer_fifo
  import link_buffer_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FLIT_W,
  parameter int DEPTH      = LINK_FIFO_DEPTH,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  link_buffer_fifo_if.slave    up,
  link_buffer_fifo_if.master   dn,
  output logic [ADDR_W:0]      count,
  output logic                 ovf_err
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_err_q, ovf_err_d;
  logic              ack_out, req_out;
  logic              wr_en, rd_en;

  // Handshake outputs come only from registered occupancy, so no comb path from req_in.
  assign ack_out = (count_q != FULL_CNT);
  assign req_out = (count_q != '0);

  always_comb begin
    wr_en     = up.req && ack_out;
    rd_en     = req_out && dn.ack;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ovf_err_d = ovf_err_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (wr_en && (count_q == FULL_CNT)) ovf_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_err_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_err_q <= ovf_err_d;
    end
  end

  link_buffer_fifo_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata (up.data),
    .raddr (rd_ptr_q),
    .rdata (dn.data)
  );

  assign up.ack  = ack_out;
  assign dn.req  = req_out;
  assign count   = count_q;
  assign ovf_err = ovf_err_q;

endmodule

// File: tb/tb_link_buffer_fifo.sv
// Directed and scoreboarded random checks of the link buffer FIFO.
module tb_link_buffer_fifo;
  import link_buffer_fifo_pkg::*;

  localparam int DW    = FLIT_W;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] count;
  logic       ovf_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  link_buffer_fifo_if #(.DATA_WIDTH(DW)) up_if ();
  link_buffer_fifo_if #(.DATA_WIDTH(DW)) dn_if ();

  link_buffer_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .ADDR_W     (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .up      (up_if.slave),
    .dn      (dn_if.master),
    .count   (count),
    .ovf_err (ovf_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] q [$];
  logic          m_ack, m_req, hold;

  initial begin
    up_if.req  = 1'b0;
    up_if.data = '0;
    dn_if.ack  = 1'b0;

    #2;
    check("rst_count", count, 0);
    check("rst_req_out", dn_if.req, 0);
    check("rst_ack_out", up_if.ack, 1);
    check("rst_data_out", dn_if.data, 0);
    check("rst_ovf", ovf_err, 0);
    step();
    rst = 1'b1;

    // fill to full, then push a fifth flit that must be refused
    for (int i = 1; i <= 4; i++) begin
      up_if.data = DW'(i);
      up_if.req  = 1'b1;
      step();
      check("fill_count", count, i);
    end
    up_if.data = DW'(5);
    check("full_ack_out", up_if.ack, 0);
    step();
    check("full_count", count, 4);
    check("full_head", dn_if.data, 1);
    check("full_ovf", ovf_err, 0);
    up_if.req = 1'b0;

    dn_if.ack = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check("drain_data", dn_if.data, k);
      check("drain_req", dn_if.req, 1);
      step();
    end
    check("drain_req_end", dn_if.req, 0);
    check("drain_count_end", count, 0);
    dn_if.ack = 1'b0;

    // simultaneous read/write at count 2, pointers wrap several times
    up_if.req = 1'b1;
    up_if.data = DW'(32'h100);
    step();
    up_if.data = DW'(32'h101);
    step();
    check("sim_pre_count", count, 2);
    dn_if.ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      up_if.data = DW'(32'h102 + i);
      check("sim_data", dn_if.data, 32'h100 + i);
      step();
      check("sim_count", count, 2);
    end
    up_if.req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("sim_tail", dn_if.data, 32'h10A + i);
      step();
    end
    check("sim_count_end", count, 0);
    dn_if.ack = 1'b0;

    // full plus read: read happens, write blocked that edge, accepted next edge
    up_if.req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      up_if.data = DW'(32'h200 + i);
      step();
    end
    check("fr_count_full", count, 4);
    up_if.data = DW'(32'h204);
    dn_if.ack  = 1'b1;
    check("fr_ack_blocked", up_if.ack, 0);
    step();
    check("fr_count_after_read", count, 3);
    check("fr_head", dn_if.data, 32'h201);
    check("fr_ack_reopen", up_if.ack, 1);
    dn_if.ack = 1'b0;
    step();
    up_if.req = 1'b0;
    check("fr_count_refill", count, 4);
    dn_if.ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("fr_drain", dn_if.data, 32'h201 + k);
      step();
    end
    check("fr_count_end", count, 0);
    dn_if.ack = 1'b0;

    // asynchronous reset mid-stream with three flits queued
    up_if.req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      up_if.data = DW'(32'h300 + i);
      step();
    end
    check("mid_count", count, 3);
    #2;
    rst        = 1'b0;
    up_if.data = DW'(32'h2A5A1);
    #1;
    check("mid_rst_count", count, 0);
    check("mid_rst_req_out", dn_if.req, 0);
    check("mid_rst_ack_out", up_if.ack, 1);
    check("mid_rst_data_out", dn_if.data, 0);
    check("mid_rst_ovf", ovf_err, 0);
    @(negedge clk);
    rst = 1'b1;
    step();
    up_if.req = 1'b0;
    check("post_rst_count", count, 1);
    check("post_rst_data", dn_if.data, 32'h2A5A1);
    check("post_rst_req", dn_if.req, 1);
    dn_if.ack = 1'b1;
    step();
    dn_if.ack = 1'b0;
    check("post_rst_drain", count, 0);

    // random traffic against a queue model
    hold = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      if (!hold) begin
        up_if.req  = 1'($urandom_range(0, 1));
        up_if.data = DW'($urandom());
      end
      dn_if.ack = 1'($urandom_range(0, 1));
      m_ack = (q.size() != DEPTH);
      m_req = (q.size() != 0);
      check("rnd_ack_out", up_if.ack, m_ack);
      check("rnd_req_out", dn_if.req, m_req);
      check("rnd_count", count, q.size());
      if (m_req) check("rnd_data", dn_if.data, q[0]);
      step();
      if (m_req && dn_if.ack) void'(q.pop_front());
      if (up_if.req && m_ack) q.push_back(up_if.data);
      hold = up_if.req && !m_ack;
    end
    up_if.req = 1'b0;
    dn_if.ack = 1'b0;
    check("rnd_ovf", ovf_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
